// File: rtl/dbus_responder_pkg.sv
// Shared data-bus types for the core-side dbus and the responders that serve it.
package dbus_responder_pkg;

    typedef logic [31:0] word_t;

    typedef struct packed {
        logic       valid;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [3:0]  strobe;
        word_t       data;
    } dbus_req_t;

    typedef struct packed {
        logic  addr_ok;
        logic  data_ok;
        word_t data;
    } dbus_resp_t;

endpackage

// File: rtl/dbus_responder_bram.sv
// Single-port word memory with byte write-enables and a registered read port.
module bram_be
    import dbus_responder_pkg::*;
#(
    parameter int WORDS = 1024
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic [3:0]               we,
    input  logic [$clog2(WORDS)-1:0] addr,
    input  word_t                    wdata,
    output word_t                    rdata
);

    word_t mem [WORDS];

    // Read returns the word as it was before this edge's write (read-first).
    always_ff @(posedge clk) begin
        if (en) begin
            for (int b = 0; b < 4; b++) begin
                if (we[b]) begin
                    mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dbus_responder.sv
// Data-bus responder: one outstanding access, fixed LATENCY from accept to data_ok,
// backed by a byte-writable block RAM.
module dbus_responder
    import dbus_responder_pkg::*;
#(
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY   = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp
);

    localparam int AW = $clog2(MEM_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state_reg, state_next;
    logic [3:0]    cnt_reg, cnt_next;
    logic          rd_reg, rd_next;
    logic          accept;
    logic          in_range;
    logic [AW-1:0] idx;
    logic [3:0]    we;
    word_t         rdata;
    logic          unused_bits;

    assign in_range    = (dreq.addr[31:AW+2] == '0);
    assign idx         = dreq.addr[AW+1:2];
    // Gating with resetn keeps addr_ok low and blocks writes while reset is held.
    assign accept      = resetn && (state_reg == IDLE) && dreq.valid;
    assign we          = (accept && in_range) ? dreq.strobe : 4'b0000;
    assign unused_bits = ^{dreq.size, dreq.addr[1:0]};

    bram_be #(.WORDS(MEM_WORDS)) u_mem (
        .clk   (clk),
        .en    (accept),
        .we    (we),
        .addr  (idx),
        .wdata (dreq.data),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            rd_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            rd_reg    <= rd_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        rd_next    = rd_reg;
        dresp      = '0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    dresp.addr_ok = 1'b1;
                    cnt_next      = 4'(LATENCY - 1);
                    // Only in-range reads return storage data; writes and misses return 0.
                    rd_next       = (dreq.strobe == 4'b0000) && in_range;
                    state_next    = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_next = cnt_reg - 4'd1;
                if (cnt_reg <= 4'd1) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                dresp.data_ok = 1'b1;
                dresp.data    = rd_reg ? rdata : '0;
                state_next    = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
